axis_to_tapa_istream: RTL and testbench

Ingress bridge placed directly upstream of a kernel stream input such as StreamAdd's a/b ports. It accepts AXI4-Stream beats in which a TLAST beat is the close token, and presents them to the kernel as a TAPA istream read interface: dout = {eot, data}, empty_n, read. A 2-entry skid buffer gives full throughput with a registered TREADY. An arm/done transfer FSM makes exactly one token-terminated transfer per arm pulse and counts the data beats.

---
 rtl/axis_tapa_pkg.sv | 19 +
 rtl/axis_to_tapa_istream_if.sv | 16 +
 rtl/axis_skid_fifo2.sv | 55 +++++
 rtl/axis_to_tapa_istream.sv | 100 ++++++++++
 tb/tb_axis_to_tapa_istream.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_tapa_pkg.sv
// Shared types for the AXI4-Stream to TAPA istream ingress bridge:
// transfer FSM states, default payload width and the default-width entry layout.
package axis_tapa_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Buffer entry as the kernel sees it on m_dout: eot sits above the payload.
    typedef struct packed {
        logic                          eot;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/axis_to_tapa_istream_if.sv
// AXI4-Stream beat bundle feeding the istream bridge; master drives beats, slave returns TREADY.
interface axis_to_tapa_istream_if #(
    parameter int DATA_WIDTH = axis_tapa_pkg::DEFAULT_DATA_WIDTH
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] TDATA;
    logic [KEEP_WIDTH-1:0] TKEEP;
    logic                  TLAST;
    logic                  TVALID;
    logic                  TREADY;

    modport master (output TDATA, TKEEP, TLAST, TVALID, input TREADY);
    modport slave  (input TDATA, TKEEP, TLAST, TVALID, output TREADY);

endinterface

// File: rtl/axis_skid_fifo2.sv
// Two-entry skid FIFO: slot0 is always the head, slot1 holds the second entry.
// count_next is exported so the parent can register TREADY against the post-edge fill level.
module axis_skid_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic [1:0]       count_next
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop     = pop && (count_q != 2'd0);
        do_push    = push && (count_q != 2'd2);
        count_next = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // A pop shifts slot1 forward; with one entry, a simultaneous push lands straight in the head.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            count_q <= 2'd0;
            slot0   <= '0;
            slot1   <= '0;
        end else begin
            count_q <= count_next;
            if (do_pop) begin
                if (count_q == 2'd2) begin
                    slot0 <= slot1;
                end else if (do_push) begin
                    slot0 <= push_data;
                end
            end else if (do_push) begin
                if (count_q == 2'd0) begin
                    slot0 <= push_data;
                end else begin
                    slot1 <= push_data;
                end
            end
        end
    end

    assign head  = (count_q != 2'd0) ? slot0 : '0;
    assign count = count_q;

endmodule

// File: rtl/axis_to_tapa_istream.sv
// AXI4-Stream to TAPA istream bridge: one TLAST-terminated transfer per arm pulse.
// Optional macro AXIS_TO_TAPA_KEEP_CHECK_EN adds the sticky partial-TKEEP flag err_keep.
module axis_to_tapa_istream
    import axis_tapa_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      arm,
    axis_to_tapa_istream_if.slave     s_axis,
    output logic [DATA_WIDTH:0]       m_dout,
    output logic                      m_empty_n,
    input  logic                      m_read,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               beat_count,
    output logic                      err_keep
);

    typedef struct packed {
        logic                  eot;
        logic [DATA_WIDTH-1:0] data;
    } stream_entry_t;

    state_t        state;
    state_t        next_state;
    logic          tready_q;
    logic          accept;
    stream_entry_t push_entry;
    stream_entry_t head_entry;
    logic [1:0]    fifo_count;
    logic [1:0]    fifo_count_next;

    assign accept     = s_axis.TVALID && tready_q;
    assign push_entry = '{eot: s_axis.TLAST, data: s_axis.TDATA};

    axis_skid_fifo2 #(
        .WIDTH ($bits(stream_entry_t))
    ) u_fifo (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .push       (accept),
        .push_data  (push_entry),
        .pop        (m_read),
        .head       (head_entry),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (arm) next_state = STREAM;
            STREAM:  if (accept && s_axis.TLAST) next_state = DRAIN;
            DRAIN:   if (fifo_count == 2'd0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // TREADY looks one edge ahead so it never promises a slot the buffer will not have.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= IDLE;
            tready_q   <= 1'b0;
            done       <= 1'b0;
            beat_count <= '0;
        end else begin
            state    <= next_state;
            tready_q <= (next_state == STREAM) && (fifo_count_next < 2'd2);
            done     <= (state == DRAIN) && (fifo_count == 2'd0);
            if (state == IDLE && arm) begin
                beat_count <= '0;
            end else if (accept && !s_axis.TLAST) begin
                beat_count <= beat_count + 32'd1;
            end
        end
    end

`ifdef AXIS_TO_TAPA_KEEP_CHECK_EN
    // Only payload beats are checked; the close token may carry any TKEEP.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            err_keep <= 1'b0;
        end else if (state == IDLE && arm) begin
            err_keep <= 1'b0;
        end else if (accept && !s_axis.TLAST && (s_axis.TKEEP != '1)) begin
            err_keep <= 1'b1;
        end
    end
`else
    assign err_keep = 1'b0;
`endif

    assign s_axis.TREADY = tready_q;
    assign m_dout        = head_entry;
    assign m_empty_n     = (fifo_count != 2'd0);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_axis_to_tapa_istream.sv
// Randomised bench for axis_to_tapa_istream against a queue-based transfer model.
// Build with AXIS_TO_TAPA_KEEP_CHECK_EN to exercise the partial-TKEEP flag.
module tb_axis_to_tapa_istream;
    import axis_tapa_pkg::*;

    localparam int DW       = DEFAULT_DATA_WIDTH;
    localparam int M_IDLE   = 0;
    localparam int M_STREAM = 1;
    localparam int M_DRAIN  = 2;
    localparam int BUDGET   = 300;
`ifdef AXIS_TO_TAPA_KEEP_CHECK_EN
    localparam bit KEEP_EN = 1'b1;
`else
    localparam bit KEEP_EN = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        arm    = 1'b0;
    logic        m_read = 1'b0;
    logic [DW:0] m_dout;
    logic        m_empty_n;
    logic        busy;
    logic        done;
    logic [31:0] beat_count;
    logic        err_keep;

    axis_to_tapa_istream_if #(.DATA_WIDTH(DW)) axis_bus ();

    axis_to_tapa_istream #(.DATA_WIDTH(DW)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .arm        (arm),
        .s_axis     (axis_bus.slave),
        .m_dout     (m_dout),
        .m_empty_n  (m_empty_n),
        .m_read     (m_read),
        .busy       (busy),
        .done       (done),
        .beat_count (beat_count),
        .err_keep   (err_keep)
    );

    always #5 ap_clk = ~ap_clk;

    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    entry_t      modelQ[$];
    int          mState   = M_IDLE;
    logic [31:0] mBeats   = '0;
    bit          mReady   = 1'b0;
    bit          mDone    = 1'b0;
    bit          mErr     = 1'b0;
    bit          lastAcc  = 1'b0;
    int          doneSeen = 0;
    int          acceptLog[$];
    logic [31:0] beatData[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic checkAll();
        entry_t headExp;
        headExp = (modelQ.size() != 0) ? modelQ[0] : '0;
        checkOutput("s_axis_TREADY", 64'(axis_bus.TREADY), 64'(mReady));
        checkOutput("m_empty_n", 64'(m_empty_n), 64'(modelQ.size() != 0));
        checkOutput("m_dout", 64'(m_dout), 64'(headExp));
        checkOutput("busy", 64'(busy), 64'(mState != M_IDLE));
        checkOutput("done", 64'(done), 64'(mDone));
        checkOutput("beat_count", 64'(beat_count), 64'(mBeats));
        checkOutput("err_keep", 64'(err_keep), 64'(mErr));
        if (done === 1'b1) doneSeen++;
    endtask

    // One clock: drive at the falling edge, advance the model, compare just after the rising edge.
    task automatic applyStimulus(input bit rstI, input bit armI, input bit validI, input logic [31:0] dataI,
                                 input bit lastI, input logic [3:0] keepI, input bit readI);
        bit acc;
        bit emptyNow;
        @(negedge ap_clk);
        ap_rst          = rstI;
        arm             = armI;
        axis_bus.TVALID = validI;
        axis_bus.TDATA  = dataI;
        axis_bus.TLAST  = lastI;
        axis_bus.TKEEP  = keepI;
        m_read          = readI;
        lastAcc         = 1'b0;
        if (rstI) begin
            modelQ.delete();
            mState = M_IDLE;
            mBeats = '0;
            mReady = 1'b0;
            mDone  = 1'b0;
            mErr   = 1'b0;
        end else begin
            acc      = validI && mReady;
            emptyNow = (modelQ.size() == 0);
            mDone    = (mState == M_DRAIN) && emptyNow;
            if (readI && !emptyNow) void'(modelQ.pop_front());
            if (acc) modelQ.push_back('{eot: lastI, data: dataI});
            case (mState)
                M_IDLE:   if (armI) begin mState = M_STREAM; mBeats = '0; mErr = 1'b0; end
                M_STREAM: if (acc && lastI) mState = M_DRAIN;
                M_DRAIN:  if (emptyNow) mState = M_IDLE;
                default:  mState = M_IDLE;
            endcase
            if (acc && !lastI) begin
                mBeats = mBeats + 32'd1;
                if (KEEP_EN && keepI != 4'hF) mErr = 1'b1;
            end
            mReady  = (mState == M_STREAM) && (modelQ.size() < 2);
            lastAcc = acc;
            if (acc) acceptLog.push_back(cycle);
        end
        @(posedge ap_clk);
        #1;
        cycle++;
        checkAll();
    endtask

    // readMode: 0 = m_read always high, 1 = low for the first 10 cycles, 2 = random.
    task automatic runTransfer(input int n, input int readMode, input bit randValid,
                               input int badKeepIdx, input bit armInDrain);
        int          idx;
        int          budget;
        bit          armedDrain;
        bit          v;
        bit          rd;
        bit          doArm;
        logic [31:0] d;
        idx        = 0;
        budget     = 0;
        armedDrain = 1'b0;
        doneSeen   = 0;
        acceptLog.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'hF, 1'b1);
        checkOutput("beat_count_after_arm", 64'(beat_count), 64'd0);
        while (!(mState == M_IDLE && idx > n) && budget < BUDGET) begin
            v     = (idx <= n) && (!randValid || $urandom_range(0, 3) != 0);
            d     = (idx < n) ? beatData[idx] : 32'h0;
            rd    = (readMode == 0) ? 1'b1 : (readMode == 1) ? (budget >= 10) : 1'($urandom_range(0, 1));
            doArm = armInDrain && (mState == M_DRAIN) && !armedDrain;
            if (doArm) armedDrain = 1'b1;
            applyStimulus(1'b0, doArm, v, d, idx == n, (idx == badKeepIdx) ? 4'h7 : 4'hF, rd);
            if (lastAcc) idx++;
            budget++;
        end
        checkOutput("xfer_in_budget", 64'(budget < BUDGET), 64'd1);
        checkOutput("beat_count_final", 64'(beat_count), 64'(n));
        checkOutput("done_pulses", 64'(doneSeen), 64'd1);
        checkOutput("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic idleCycles(input int k, input bit validI);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, validI, 32'hDEAD_0000 + 32'(i), 1'b0, 4'hF, 1'b1);
    endtask

    initial begin
        axis_bus.TVALID = 1'b0;
        axis_bus.TDATA  = '0;
        axis_bus.TLAST  = 1'b0;
        axis_bus.TKEEP  = '1;

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234, 1'b0, 4'hF, 1'b1);
        idleCycles(2, 1'b0);

        $display("[TB] single transfer, kernel always reading");
        beatData = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        runTransfer(5, 0, 1'b0, -1, 1'b0);

        $display("[TB] backpressure, kernel stalled for 10 cycles");
        runTransfer(5, 1, 1'b0, -1, 1'b0);

        $display("[TB] gating: TVALID before arm, arm during drain, re-arm");
        idleCycles(3, 1'b1);
        runTransfer(5, 1, 1'b0, -1, 1'b1);
        idleCycles(2, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'hF, 1'b1);
        checkOutput("rearm_clears_count", 64'(beat_count), 64'd0);
        idleCycles(3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0);

        $display("[TB] simultaneous push/pop streaming");
        beatData.delete();
        for (int i = 0; i < 8; i++) beatData.push_back($urandom);
        runTransfer(8, 0, 1'b0, -1, 1'b0);
        checkOutput("accepts_logged", 64'(acceptLog.size()), 64'd9);
        if (acceptLog.size() == 9)
            checkOutput("one_beat_per_cycle", 64'(acceptLog[8] - acceptLog[0]), 64'd8);

        $display("[TB] reset after 2 of 5 beats");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 4'hF, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hAAAA_0002, 1'b0, 4'hF, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hAAAA_0003, 1'b0, 4'hF, 1'b1);
        checkOutput("rst_empty_n", 64'(m_empty_n), 64'd0);
        checkOutput("rst_tready", 64'(axis_bus.TREADY), 64'd0);
        checkOutput("rst_beat_count", 64'(beat_count), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        idleCycles(2, 1'b1);

        $display("[TB] partial TKEEP on a payload beat");
        beatData = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 32'h5555_0000};
        runTransfer(5, 2, 1'b1, 3, 1'b0);
        checkOutput("err_keep_after", 64'(err_keep), 64'(KEEP_EN));
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'hF, 1'b1);
        checkOutput("err_keep_cleared_by_arm", 64'(err_keep), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF, 1'b0);

        $display("[TB] randomised transfers");
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 8);
            beatData.delete();
            for (int i = 0; i < n; i++) beatData.push_back($urandom);
            runTransfer(n, 2, 1'b1, (t % 2 == 0) ? -1 : int'($urandom_range(0, n - 1)), t[0]);
            idleCycles(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
